// File: rtl/rr_mux_sel_arbiter_pkg.sv
// Shared definitions for the round-robin mux-select arbiter.
//   - FSM state encoding (IDLE / GRANT)
//   - default requester count and select width
package rr_mux_sel_arbiter_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int SEL_W_DEF = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_next_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index of the last owner; the search starts at ptr+1
//   found : at least one request bit is set
//   idx   : first requester found scanning ptr+1, ptr+2, ... (mod N_REQ)
// Rotate so that ptr+1 lands at bit 0, priority-encode the lowest set bit,
// then add the start offset back. N_REQ must equal 2**SEL_W so that the
// SEL_W-bit additions wrap exactly modulo N_REQ.
module rr_next_pick #(
  parameter int N_REQ = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  assign start = ptr + SEL_W'(1);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi] = req[start + SEL_W'(gi)];
  end

  // Descending loop so the lowest set bit is the one left standing.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SEL_W'(i);
      end
    end
  end

  assign idx = start + off;

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester level request
//   ack         : downstream consumed the muxed data this cycle
//   sel         : registered mux select (holds last value while idle)
//   gnt         : registered one-hot grant, zero when idle
//   out_valid   : mux output valid (== |gnt)
//   timeout_err : one-cycle pulse when the watchdog forces a release
// A grant is held until ack; on ack the next requester is picked in the
// same edge. An owner that drops its request, or holds the grant for
// TIMEOUT cycles without ack, is released to IDLE.
module rr_mux_sel_arbiter
  import rr_mux_sel_arbiter_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int SEL_W   = SEL_W_DEF,
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             ack,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] gnt,
  output logic             out_valid,
  output logic             timeout_err
);

  if (N_REQ != 4 || SEL_W != 2) begin : g_bad_width
    $error("rr_mux_sel_arbiter: N_REQ must be 4 and SEL_W 2 to match the mux");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255 || TIMEOUT >= (1 << TMO_W)) begin : g_bad_tmo
    $error("rr_mux_sel_arbiter: TIMEOUT out of range");
  end

  state_e           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;
  logic [N_REQ-1:0] gnt_q;
  logic             valid_q;
  logic             tmo_q;
  logic [TMO_W-1:0] wd_q;
  logic [TMO_W-1:0] wd_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             wd_expired;
  logic             do_grant;
  logic             do_release;
  logic             do_tmo;

  rr_next_pick #(
    .N_REQ (N_REQ),
    .SEL_W (SEL_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Saturating watchdog increment.
  assign wd_d       = (wd_q == {TMO_W{1'b1}}) ? wd_q : wd_q + TMO_W'(1);
  assign wd_expired = (wd_q == TMO_W'(TIMEOUT - 1));

  // While granted, ptr holds the owner, so a search from ptr+1 reaches the
  // owner last: others win if present, otherwise the owner is re-granted.
  // ack takes precedence over both withdrawal and watchdog expiry.
  assign do_grant   = pick_found && (state_q == ST_IDLE || ack);
  assign do_release = (state_q == ST_GRANT) && !do_grant &&
                      (ack || !req[sel_q] || wd_expired);
  assign do_tmo     = (state_q == ST_GRANT) && !ack && req[sel_q] && wd_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= '1;
      ptr_q   <= '1;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      tmo_q <= do_tmo;
      if (do_grant) begin
        state_q <= ST_GRANT;
        sel_q   <= pick_idx;
        ptr_q   <= pick_idx;
        gnt_q   <= N_REQ'(1) << pick_idx;
        valid_q <= 1'b1;
        wd_q    <= '0;
      end else if (do_release) begin
        // ptr stays at the released owner: it becomes lowest priority.
        state_q <= ST_IDLE;
        gnt_q   <= '0;
        valid_q <= 1'b0;
      end else if (state_q == ST_GRANT) begin
        wd_q <= wd_d;
      end
    end
  end

  assign sel         = sel_q;
  assign gnt         = gnt_q;
  assign out_valid   = valid_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Self-checking bench for rr_mux_sel_arbiter: directed scenarios with
// literal expectations plus a randomized phase, all compared every cycle
// against a behavioural model of the arbitration rules.
module tb_rr_mux_sel_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       ack;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       out_valid;
  logic       timeout_err;

  int n_total = 0;
  int n_pass  = 0;

  rr_mux_sel_arbiter #(
    .N_REQ   (4),
    .SEL_W   (2),
    .TIMEOUT (TIMEOUT),
    .TMO_W   (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .sel         (sel),
    .gnt         (gnt),
    .out_valid   (out_valid),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // owner = -1 when idle; ptr = last owner; wd = cycles held without ack.
  int m_owner = -1;
  int m_ptr   = 3;
  int m_wd    = 0;
  int m_sel   = 3;
  bit m_tmo   = 1'b0;

  function automatic int pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int w, owner, ptr, wd, sl;
    bit tmo;
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 3;
      m_wd    <= 0;
      m_sel   <= 3;
      m_tmo   <= 1'b0;
    end else begin
      owner = m_owner; ptr = m_ptr; wd = m_wd; sl = m_sel; tmo = 1'b0;
      w = pick(req, ptr);
      if (owner < 0 || ack) begin
        if (w >= 0) begin
          owner = w; ptr = w; sl = w; wd = 0;
        end else begin
          owner = -1;
        end
      end else if (!req[owner]) begin
        owner = -1;
      end else if (wd == TIMEOUT - 1) begin
        owner = -1;
        tmo   = 1'b1;
      end else if (wd < 255) begin
        wd = wd + 1;
      end
      m_owner <= owner;
      m_ptr   <= ptr;
      m_wd    <= wd;
      m_sel   <= sl;
      m_tmo   <= tmo;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(posedge clk) begin : compare
    int idx;
    #1;
    chk("gnt", gnt, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("sel", sel, m_sel);
    chk("out_valid", out_valid, (m_owner >= 0) ? 1 : 0);
    chk("timeout_err", timeout_err, m_tmo);
    chk("gnt_onehot0", ($countones(gnt) <= 1) ? 1 : 0, 1);
    chk("valid_eq_or_gnt", out_valid, |gnt);
    if (gnt != 4'b0000) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (gnt[i]) idx = i;
      chk("sel_matches_gnt", sel, idx);
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [3:0] seq_gnt [5];
    int n;
    int ack_pct;
    int req_pct;
    seq_gnt[0] = 4'b0001; seq_gnt[1] = 4'b0010; seq_gnt[2] = 4'b0100;
    seq_gnt[3] = 4'b1000; seq_gnt[4] = 4'b0001;

    rst_n = 1'b0;
    req   = 4'b0000;
    ack   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: idle after reset
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      chk("t1_gnt", gnt, 4'b0000);
      chk("t1_valid", out_valid, 1'b0);
      chk("t1_sel", sel, 2'b11);
    end

    // 2: all request, ack every cycle -> rotate with no bubbles
    @(negedge clk) begin req = 4'b1111; ack = 1'b1; end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #2;
      chk("t2_gnt", gnt, seq_gnt[k]);
      chk("t2_sel", sel, k % 4);
    end
    @(negedge clk) req = 4'b0000;
    @(posedge clk); #2;
    chk("t2_idle", gnt, 4'b0000);
    @(negedge clk) ack = 1'b0;

    // 3: single request from idle
    @(negedge clk) req = 4'b0100;
    @(posedge clk); #2;
    chk("t3_gnt", gnt, 4'b0100);
    chk("t3_sel", sel, 2);
    chk("t3_valid", out_valid, 1'b1);
    @(negedge clk) begin req = 4'b0000; ack = 1'b1; end
    @(posedge clk); #2;
    chk("t3_release", gnt, 4'b0000);
    @(negedge clk) ack = 1'b0;

    // 4: watchdog
    @(negedge clk) req = 4'b0001;
    @(posedge clk); #2;
    chk("t4_gnt", gnt, 4'b0001);
    n = 0;
    while (n <= 40) begin
      @(posedge clk); #2;
      n++;
      if (timeout_err) break;
    end
    chk("t4_tmo_latency", n, TIMEOUT);
    chk("t4_gnt_cleared", gnt, 4'b0000);
    @(negedge clk) req = 4'b0011;
    @(posedge clk); #2;
    chk("t4_next_owner", gnt, 4'b0010);
    chk("t4_pulse_once", timeout_err, 1'b0);
    @(negedge clk) begin req = 4'b0000; ack = 1'b1; end
    @(negedge clk) ack = 1'b0;

    // 5: withdrawal, then ack on the expiry cycle
    @(negedge clk) req = 4'b0100;
    @(posedge clk); #2;
    chk("t5_gnt", gnt, 4'b0100);
    @(negedge clk) req = 4'b0000;
    @(posedge clk); #2;
    chk("t5_withdraw_gnt", gnt, 4'b0000);
    chk("t5_withdraw_tmo", timeout_err, 1'b0);
    @(negedge clk) req = 4'b0100;
    @(posedge clk); #2;
    chk("t5_regrant", gnt, 4'b0100);
    repeat (TIMEOUT - 1) @(posedge clk);
    @(negedge clk) ack = 1'b1;
    @(posedge clk); #2;
    chk("t5_ack_beats_wd", timeout_err, 1'b0);
    chk("t5_ack_regrant", gnt, 4'b0100);
    @(negedge clk) req = 4'b0000;
    @(negedge clk) ack = 1'b0;

    // random phase
    for (int seg = 0; seg < 32; seg++) begin
      case (seg % 4)
        0:       ack_pct = 0;
        1:       ack_pct = 5;
        2:       ack_pct = 40;
        default: ack_pct = 90;
      endcase
      req_pct = (seg % 8 < 4) ? 10 : 40;
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        if ($urandom_range(99) < req_pct) req = 4'($urandom);
        ack = ($urandom_range(99) < ack_pct);
      end
    end

    // 6: asynchronous reset mid-grant
    @(negedge clk) begin req = 4'b0000; ack = 1'b1; end
    @(negedge clk) begin ack = 1'b0; req = 4'b1000; end
    @(posedge clk); #2;
    chk("t6_gnt", gnt, 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_gnt", gnt, 4'b0000);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_sel", sel, 2'b11);
    chk("t6_rst_tmo", timeout_err, 1'b0);
    @(negedge clk) req = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #3;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
